// File: rtl/bout_sequencer.sv
// Round-flow sequencer for a fencing bout: countdown, fencing, post-touch pause and
// bout-over phases, score keeping and winner declaration for the HUD and action FSM.
module bout_sequencer #(
    parameter int unsigned SEC_CYCLES     = 74_250_000,
    parameter int unsigned COUNTDOWN_SECS = 3,
    parameter int unsigned PAUSE_SECS     = 2,
    parameter int unsigned TARGET_SCORE   = 5
) (
    input  logic       clk_pixel_in,
    input  logic       rst_n_in,
    input  logic       start_in,
    input  logic       abort_in,
    input  logic       touch_valid_in,
    input  logic       player_scored_in,
    input  logic       opponent_scored_in,
    output logic       fsm_enable_out,
    output logic       fsm_hold_out,
    output logic [2:0] phase_out,
    output logic [3:0] countdown_sec_out,
    output logic [3:0] player_score_out,
    output logic [3:0] opponent_score_out,
    output logic [1:0] touch_out,
    output logic [1:0] winner_out
);

    localparam int unsigned TICK_W = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SEC_CYCLES - 1);
    localparam logic [3:0] CD_LOAD    = 4'(COUNTDOWN_SECS);
    localparam logic [3:0] PAUSE_LOAD = 4'(PAUSE_SECS);
    localparam logic [3:0] TARGET     = 4'(TARGET_SCORE);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_FENCE     = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_DONE      = 3'd4
    } phase_t;

    phase_t            state;
    logic [TICK_W-1:0] tick;
    logic [3:0]        secs;
    logic              tick_wrap;
    logic              touch_hit;
    logic [3:0]        player_next;
    logic [3:0]        opponent_next;

    // Scores stop at the target so a 4-bit counter never wraps, even at 15.
    function automatic logic [3:0] sat_inc(input logic [3:0] score, input logic hit);
        if (hit && (score < TARGET)) begin
            return score + 4'd1;
        end
        return score;
    endfunction

    assign tick_wrap     = (tick == TICK_LAST);
    assign touch_hit     = touch_valid_in & (player_scored_in | opponent_scored_in);
    assign player_next   = sat_inc(player_score_out, player_scored_in);
    assign opponent_next = sat_inc(opponent_score_out, opponent_scored_in);
    assign phase_out     = state;

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state              <= ST_IDLE;
            tick               <= '0;
            secs               <= 4'd0;
            fsm_enable_out     <= 1'b0;
            fsm_hold_out       <= 1'b1;
            countdown_sec_out  <= 4'd0;
            player_score_out   <= 4'd0;
            opponent_score_out <= 4'd0;
            touch_out          <= 2'b00;
            winner_out         <= 2'b00;
        end else begin
            touch_out <= 2'b00;
            if (abort_in) begin
                state              <= ST_IDLE;
                tick               <= '0;
                secs               <= 4'd0;
                fsm_enable_out     <= 1'b0;
                fsm_hold_out       <= 1'b1;
                countdown_sec_out  <= 4'd0;
                player_score_out   <= 4'd0;
                opponent_score_out <= 4'd0;
                winner_out         <= 2'b00;
            end else begin
                case (state)
                    ST_IDLE: begin
                        player_score_out   <= 4'd0;
                        opponent_score_out <= 4'd0;
                        if (start_in) begin
                            state             <= ST_COUNTDOWN;
                            tick              <= '0;
                            secs              <= CD_LOAD;
                            countdown_sec_out <= CD_LOAD;
                        end
                    end
                    ST_COUNTDOWN: begin
                        if (tick_wrap) begin
                            tick <= '0;
                            if (secs == 4'd1) begin
                                state             <= ST_FENCE;
                                secs              <= 4'd0;
                                countdown_sec_out <= 4'd0;
                                fsm_enable_out    <= 1'b1;
                                fsm_hold_out      <= 1'b0;
                            end else begin
                                secs              <= secs - 4'd1;
                                countdown_sec_out <= secs - 4'd1;
                            end
                        end else begin
                            tick <= tick + TICK_W'(1);
                        end
                    end
                    ST_FENCE: begin
                        if (touch_hit) begin
                            player_score_out   <= player_next;
                            opponent_score_out <= opponent_next;
                            touch_out          <= {opponent_scored_in, player_scored_in};
                            fsm_enable_out     <= 1'b0;
                            fsm_hold_out       <= 1'b1;
                            if ((player_next == TARGET) || (opponent_next == TARGET)) begin
                                state      <= ST_DONE;
                                winner_out <= {opponent_next == TARGET, player_next == TARGET};
                            end else begin
                                state <= ST_PAUSE;
                                tick  <= '0;
                                secs  <= PAUSE_LOAD;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (tick_wrap) begin
                            tick <= '0;
                            if (secs == 4'd1) begin
                                state             <= ST_COUNTDOWN;
                                secs              <= CD_LOAD;
                                countdown_sec_out <= CD_LOAD;
                            end else begin
                                secs <= secs - 4'd1;
                            end
                        end else begin
                            tick <= tick + TICK_W'(1);
                        end
                    end
                    ST_DONE: begin
                        if (start_in) begin
                            state              <= ST_COUNTDOWN;
                            tick               <= '0;
                            secs               <= CD_LOAD;
                            countdown_sec_out  <= CD_LOAD;
                            player_score_out   <= 4'd0;
                            opponent_score_out <= 4'd0;
                            winner_out         <= 2'b00;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
